gate_response_checker: RTL and testbench
========================================

# gate_response_checker

- Self-checking response monitor for two-input logic-gate DUTs in the lab designs.
- Accepts observed input/output vectors (A, B, Y) through a valid/ready handshake and compares Y against the expected function selected by GATE_OP.
- Counts passes and failures, tracks truth-table coverage, and captures the first failing vector.
- Sits downstream of a stimulus source and DUT, forming the checking end of the stimulus/response loop.

## Interface
- GATE_OP, default 1: expected function. 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR; any other value behaves as OR.
- CNT_W, default 8: width of pass/fail counters.

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; clears results and begins a run
- s_valid  in  1  observed vector valid
- s_ready  out  1  checker can accept a vector
- a_in  in  1  observed DUT input A
- b_in  in  1  observed DUT input B
- y_in  in  1  observed DUT output Y
- pass_cnt  out  CNT_W  matching vectors this run, saturating
- fail_cnt  out  CNT_W  mismatching vectors this run, saturating
- coverage  out  4  bit {a_in,b_in} set once that combination has been accepted this run
- busy  out  1  high in RUN
- done  out  1  high in DONE
- error  out  1  sticky; set on first mismatch of the run
- first_fail_vec  out  3  {a,b,y} of first mismatch this run; valid when error=1

## Operation
- States:
  - IDLE: reset state.
  - RUN: accepting vectors.
  - DONE: all four combinations covered.
- Transitions:
  - IDLE -start-> RUN.
  - RUN -(coverage becomes 4'b1111 on an accept)-> DONE.
  - RUN -start-> RUN, with results cleared.
  - DONE -start-> RUN, with results cleared.
- Clearing on start: pass_cnt, fail_cnt, coverage, error, first_fail_vec all go to 0 on the start edge.
- s_ready = (state==RUN) && !start. This is combinational; start has priority, so a vector offered in a start cycle is not accepted.
- Accept = s_valid && s_ready. On an accept edge:
  - expected = f_GATE_OP(a_in,b_in).
  - If y_in==expected, pass_cnt increments; otherwise fail_cnt increments.
  - coverage[{a_in,b_in}] is set.
  - On a mismatch with error==0: error is set and first_fail_vec = {a_in,b_in,y_in}. Later mismatches do not overwrite it.
- Counters saturate at 2^CNT_W-1 and never wrap. Saturation does not stop acceptance.
- Coverage and done are independent of pass/fail. A run with failures still reaches DONE once all combinations are seen.
- Inputs are ignored outside accept cycles. X on a_in/b_in/y_in while not accepting must not affect state.

## Timing
- Reset values: state IDLE, s_ready 0, pass_cnt 0, fail_cnt 0, coverage 0, busy 0, done 0, error 0, first_fail_vec 0.
- Latency: outputs reflect an accepted vector in the cycle after the accept edge (1-cycle latency). Throughput is one vector per cycle.
- done and busy: done rises and busy falls in the cycle after the accept that completes coverage. s_ready is 0 from that cycle onward.
- start: busy=1 and all results are 0 in the cycle after the start edge.
- rst asserted mid-run: all outputs return to their reset values immediately (asynchronously). No accept occurs while rst is high. Deassertion lands in IDLE; a new start is required.
- Simultaneous start and s_valid: start wins and the vector is dropped. The source must hold it until s_ready.

## Test plan
- Reset: hold rst high 3 cycles with s_valid=1 -> all outputs 0, s_ready=0, no counting.
- Clean OR run (GATE_OP=1): start, then vectors 00/0, 01/1, 10/1, 11/1 back-to-back -> pass_cnt=4, fail_cnt=0, coverage=4'b1111, done=1 one cycle after the 4th accept, s_ready=0.
- Faults: start, then 10/0, then 11/0, 00/0, 01/1 -> fail_cnt=2, pass_cnt=2, error=1, first_fail_vec=3'b100 (not 3'b110), done=1.
- Saturation (CNT_W=8): start, then 300 × 00/0 -> pass_cnt=255, coverage=4'b0001, done=0, s_ready stays 1.
- Restart and reset:
  - After 2 accepted vectors in RUN, pulse start with s_valid=1 -> results cleared and that vector not counted.
  - Then after 1 more accept, assert rst -> all outputs 0, state IDLE.
- XOR (GATE_OP=2): start, then 00/0, 01/1, 10/1, 11/0 -> pass_cnt=4, error=0.
- OR-specific vector under XOR: 11/1 under GATE_OP=2 -> fail_cnt=1, first_fail_vec=3'b111.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker
// Checking end of a gate-level stimulus/response loop: accepts observed
// {a,b,y} vectors over valid/ready, compares y against the selected
// two-input function, counts passes/failures with saturation, tracks
// truth-table coverage and latches the first failing vector of a run.
module gate_response_checker #(
    parameter int GATE_OP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             y_in,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       coverage,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic       accept;
    logic       exp_y;
    logic       mismatch;
    logic [1:0] combo;
    logic [3:0] cov_next;

    // Reference function of the gate under test; unknown codes fall back to OR.
    function automatic logic gate_fn(input logic a, input logic b);
        logic r;
        case (GATE_OP)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            3:       r = ~(a & b);
            4:       r = ~(a | b);
            5:       r = ~(a ^ b);
            default: r = a | b;
        endcase
        return r;
    endfunction

    // Start has priority over an offered vector, so ready drops in a start cycle.
    assign s_ready = (state == RUN) && !start;
    assign accept  = s_valid && s_ready;

    // Per-vector compare and the coverage map that would result from accepting it.
    always_comb begin
        combo    = {a_in, b_in};
        exp_y    = gate_fn(a_in, b_in);
        mismatch = (y_in != exp_y);
        cov_next = coverage | (4'b0001 << combo);
    end

    // Run-control FSM together with all result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            coverage       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            first_fail_vec <= '0;
        end else if (start) begin
            // Any state restarts a fresh run on start.
            state          <= RUN;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            coverage       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (mismatch) begin
                            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                            if (!error) begin
                                error          <= 1'b1;
                                first_fail_vec <= {a_in, b_in, y_in};
                            end
                        end else begin
                            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                        end
                        coverage <= cov_next;
                        if (cov_next == 4'b1111) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker: an OR instance and an XOR instance
// share one stimulus stream and are checked against a truth-table model.
module tb_gate_response_checker;

    localparam int SAT = (1 << 8) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic a_in = 1'b0, b_in = 1'b0, y_in = 1'b0;

    logic       s_ready [2];
    logic [7:0] pass_cnt [2];
    logic [7:0] fail_cnt [2];
    logic [3:0] coverage [2];
    logic       busy [2];
    logic       done [2];
    logic       error [2];
    logic [2:0] first_fail_vec [2];

    // Model: truth table per instance (bit index = {a,b}) and run results.
    logic [3:0] tt [2];
    int         m_pass [2];
    int         m_fail [2];
    logic [3:0] m_cov [2];
    bit         m_run [2];
    bit         m_done [2];
    bit         m_err [2];
    logic [2:0] m_ffv [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gate_response_checker #(.GATE_OP(1), .CNT_W(8)) u_or (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready[0]),
        .a_in(a_in), .b_in(b_in), .y_in(y_in),
        .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]), .coverage(coverage[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .first_fail_vec(first_fail_vec[0])
    );

    gate_response_checker #(.GATE_OP(2), .CNT_W(8)) u_xor (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready[1]),
        .a_in(a_in), .b_in(b_in), .y_in(y_in),
        .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]), .coverage(coverage[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .first_fail_vec(first_fail_vec[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pass[k] = 0; m_fail[k] = 0; m_cov[k] = '0;
            m_run[k] = 0; m_done[k] = 0; m_err[k] = 0; m_ffv[k] = '0;
        end
    endtask

    // Apply the rules of one clock edge to the model, using pre-edge state.
    task automatic model_edge();
        int idx;
        bit hit;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pass[k] = 0; m_fail[k] = 0; m_cov[k] = '0;
                m_run[k] = 0; m_done[k] = 0; m_err[k] = 0; m_ffv[k] = '0;
            end else if (start) begin
                m_pass[k] = 0; m_fail[k] = 0; m_cov[k] = '0;
                m_run[k] = 1; m_done[k] = 0; m_err[k] = 0; m_ffv[k] = '0;
            end else if (m_run[k] && s_valid) begin
                idx = a_in * 2 + b_in;
                hit = (y_in == tt[k][idx]);
                if (hit) begin
                    if (m_pass[k] < SAT) m_pass[k]++;
                end else begin
                    if (m_fail[k] < SAT) m_fail[k]++;
                    if (!m_err[k]) begin
                        m_err[k] = 1;
                        m_ffv[k] = {a_in, b_in, y_in};
                    end
                end
                m_cov[k][idx] = 1'b1;
                if (m_cov[k] == 4'hF) begin
                    m_run[k] = 0;
                    m_done[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/%0d/pass_cnt", tag, k), 32'(pass_cnt[k]), 32'(m_pass[k]));
            chk($sformatf("%s/%0d/fail_cnt", tag, k), 32'(fail_cnt[k]), 32'(m_fail[k]));
            chk($sformatf("%s/%0d/coverage", tag, k), 32'(coverage[k]), 32'(m_cov[k]));
            chk($sformatf("%s/%0d/busy", tag, k), 32'(busy[k]), 32'(m_run[k]));
            chk($sformatf("%s/%0d/done", tag, k), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("%s/%0d/error", tag, k), 32'(error[k]), 32'(m_err[k]));
            chk($sformatf("%s/%0d/ffv", tag, k), 32'(first_fail_vec[k]), 32'(m_ffv[k]));
            chk($sformatf("%s/%0d/s_ready", tag, k), 32'(s_ready[k]),
                32'(m_run[k] && !start && !rst));
        end
    endtask

    // One cycle: drive at negedge, check ready, take the edge, check results.
    task automatic step(input string tag, input logic r, input logic st, input logic sv,
                        input logic a, input logic b, input logic y);
        @(negedge clk);
        rst = r; start = st; s_valid = sv; a_in = a; b_in = b; y_in = y;
        if (r) model_reset();
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s/%0d/s_ready_pre", tag, k), 32'(s_ready[k]),
                32'(m_run[k] && !st && !r));
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic vec(input string tag, input logic a, input logic b, input logic y);
        step(tag, 1'b0, 1'b0, 1'b1, a, b, y);
    endtask

    task automatic do_start(input string tag);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tt[0] = 4'b1110;   // OR  indexed by {a,b}
        tt[1] = 4'b0110;   // XOR indexed by {a,b}
        model_reset();

        // Reset held with a vector offered: nothing counts.
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset/pass_const", 32'(pass_cnt[0]), 32'd0);
        step("idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Clean OR run.
        do_start("or_start");
        chk("or_start/busy_const", 32'(busy[0]), 32'd1);
        vec("or_v0", 0, 0, 0);
        vec("or_v1", 0, 1, 1);
        vec("or_v2", 1, 0, 1);
        vec("or_v3", 1, 1, 1);
        chk("or/pass_const", 32'(pass_cnt[0]), 32'd4);
        chk("or/done_const", 32'(done[0]), 32'd1);
        chk("or/ready_const", 32'(s_ready[0]), 32'd0);
        vec("or_after_done", 0, 0, 1);

        // Faults: first failure captured, later ones do not overwrite.
        do_start("flt_start");
        vec("flt_v0", 1, 0, 0);
        vec("flt_v1", 1, 1, 0);
        vec("flt_v2", 0, 0, 0);
        vec("flt_v3", 0, 1, 1);
        chk("flt/fail_const", 32'(fail_cnt[0]), 32'd2);
        chk("flt/ffv_const", 32'(first_fail_vec[0]), 32'h4);
        chk("flt/done_const", 32'(done[0]), 32'd1);

        // Clean XOR run.
        do_start("xor_start");
        vec("xor_v0", 0, 0, 0);
        vec("xor_v1", 0, 1, 1);
        vec("xor_v2", 1, 0, 1);
        vec("xor_v3", 1, 1, 0);
        chk("xor/pass_const", 32'(pass_cnt[1]), 32'd4);
        chk("xor/error_const", 32'(error[1]), 32'd0);

        // OR-style 11/1 against XOR.
        do_start("x11_start");
        vec("x11_v", 1, 1, 1);
        chk("x11/fail_const", 32'(fail_cnt[1]), 32'd1);
        chk("x11/ffv_const", 32'(first_fail_vec[1]), 32'h7);

        // Saturation.
        do_start("sat_start");
        for (int i = 0; i < 300; i++) vec("sat", 0, 0, 0);
        chk("sat/pass_const", 32'(pass_cnt[0]), 32'd255);
        chk("sat/cov_const", 32'(coverage[0]), 32'h1);
        chk("sat/done_const", 32'(done[0]), 32'd0);
        chk("sat/ready_const", 32'(s_ready[0]), 32'd1);

        // Restart mid-run with a vector offered in the start cycle.
        do_start("rs_start");
        vec("rs_v0", 0, 1, 1);
        vec("rs_v1", 1, 0, 0);
        step("rs_restart", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rs/pass_const", 32'(pass_cnt[0]), 32'd0);
        chk("rs/cov_const", 32'(coverage[0]), 32'd0);
        vec("rs_v2", 1, 1, 1);

        // Idle RUN cycles with unknown data must not disturb state.
        for (int i = 0; i < 3; i++) step("xdata", 1'b0, 1'b0, 1'b0, 1'bx, 1'bx, 1'bx);

        // Asynchronous reset mid-run: outputs clear before any edge.
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        step("rst_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Randomized traffic, including occasional start and reset.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
